// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload widths, bubble encoding and
// the occupancy encoding of an elastic pipeline stage.
package pipe_pkg;

    // Default payload widths for each inter-stage register
    localparam int unsigned IF_ID_W    = 64;
    localparam int unsigned ID_EX_W    = 160;
    localparam int unsigned EX_MEM_W   = 112;
    localparam int unsigned MEM_WB_W   = 80;
    localparam int unsigned PERF_CNT_W = 16;

    // All-zero instruction word is decoded as a NOP, so bubbles are zero-filled
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy: bit 0 = main entry valid, bit 1 = skid entry valid.
    // 2'b10 (skid without main) is not a legal encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a variable increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 2
) (
    input  logic             Clk,
    input  logic             clr,
    input  logic             inc,
    input  logic [AMT_W-1:0] inc_amt,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH:0] sum;

    // One extra bit catches the wrap so the count sticks at all-ones
    always_comb begin
        sum = {1'b0, count} + (WIDTH+1)'(inc_amt);
    end

    // Count register: clear wins over increment
    always_ff @(posedge Clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, hazard stall,
// flush-to-bubble and a one-entry skid so in_ready comes from a flop.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_INSTR),
    parameter int unsigned       CNT_W       = PERF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Reject degenerate widths at elaboration
    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_reg: DATA_W and CNT_W must be at least 1");
    end

    occ_e              state_q;
    occ_e              state_n;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_d_n;
    logic [DATA_W-1:0] skid_d;
    logic [DATA_W-1:0] skid_d_n;
    logic              main_v;
    logic              skid_v;
    logic              in_fire;
    logic              out_fire;

    assign main_v   = state_q[0];
    assign skid_v   = state_q[1];
    assign in_fire  = in_valid & ~skid_v & ~Stall;
    assign out_fire = main_v & out_ready & ~Stall;

    // Occupancy state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_n;
        end
    end

    // Payload registers; reset reloads the bubble pattern
    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_d <= BUBBLE_DATA;
            skid_d <= BUBBLE_DATA;
        end else begin
            main_d <= main_d_n;
            skid_d <= skid_d_n;
        end
    end

    // Next occupancy and payload: flush squashes everything, stall holds
    always_comb begin
        state_n  = state_q;
        main_d_n = main_d;
        skid_d_n = skid_d;
        if (Flush) begin
            state_n  = EMPTY;
            main_d_n = BUBBLE_DATA;
            skid_d_n = BUBBLE_DATA;
        end else if (!Stall) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_n  = ONE;
                        main_d_n = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d_n = in_data;
                    end else if (in_fire) begin
                        state_n  = FULL;
                        skid_d_n = in_data;
                    end else if (out_fire) begin
                        state_n  = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_n  = ONE;
                        main_d_n = skid_d;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs come from state flops, masked while stalled
    always_comb begin
        in_ready  = ~skid_v & ~Stall;
        out_valid = main_v & ~Stall;
        out_data  = main_d;
    end

    // A skid entry must never exist without a main entry
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (!(skid_v && !main_v));
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [1:0] squash_amt;

    // Number of live entries discarded by a flush
    always_comb begin
        squash_amt = {1'b0, main_v} + {1'b0, skid_v};
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .AMT_W (2)
    ) u_stall_cnt (
        .Clk     (Clk),
        .clr     (Reset),
        .inc     (Stall & main_v),
        .inc_amt (2'd1),
        .count   (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .AMT_W (2)
    ) u_flush_cnt (
        .Clk     (Clk),
        .clr     (Reset),
        .inc     (Flush),
        .inc_amt (squash_amt),
        .count   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues every accepted
// payload, a monitor pops and compares on each downstream transfer.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Stall = 1'b0;
    logic          Flush = 1'b0;
    logic          in_valid = 1'b1;
    logic          in_ready;
    logic [DW-1:0] in_data = 64'hAA;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    logic [DW-1:0] sb_q[$];
    int            checks    = 0;
    int            failures  = 0;
    int            delivered = 0;
    int            d0;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .Flush     (Flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; accepted payloads go into the scoreboard
    task automatic step(input bit rst, input bit v, input logic [DW-1:0] d,
                        input bit ordy, input bit st, input bit fl);
        @(posedge Clk);
        #1;
        Reset     = rst;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        Stall     = st;
        Flush     = fl;
        @(negedge Clk);
        #1;
        if (Reset || Flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready && !Stall) begin
            sb_q.push_back(in_data);
        end
    endtask

    // Monitor: handshake levels against queue occupancy, data on each transfer
    always @(negedge Clk) begin
        if (!Reset) begin
            check("in_ready", 64'(in_ready), 64'((sb_q.size() < 2) && !Stall));
            check("out_valid", 64'(out_valid), 64'((sb_q.size() > 0) && !Stall));
            if (out_valid && out_ready && !Stall) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    check("out_data", out_data, sb_q[0]);
                    void'(sb_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    initial begin
        // Reset with a live input offered: nothing may be captured
        step(1, 1, 64'hAA, 0, 0, 0);
        step(1, 1, 64'hAA, 0, 0, 0);
        step(0, 0, 64'h0, 1, 0, 0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", out_data, 64'h0);
`ifdef PIPE_PERF_CNT_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

        // Streaming at full rate
        d0 = delivered;
        step(0, 1, 64'h1, 1, 0, 0);
        check("first_not_yet", 64'(delivered - d0), 64'd0);
        for (int i = 2; i <= 8; i++) begin
            step(0, 1, 64'(i), 1, 0, 0);
            if (i == 2) check("first_latency", 64'(delivered - d0), 64'd1);
        end
        step(0, 0, 64'h0, 1, 0, 0);
        check("stream_count", 64'(delivered - d0), 64'd8);

        // Backpressure fills the skid entry
        step(0, 1, 64'h10, 0, 0, 0);
        step(0, 1, 64'h11, 0, 0, 0);
        step(0, 0, 64'h0, 0, 0, 0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", out_data, 64'h10);
        d0 = delivered;
        step(0, 0, 64'h0, 1, 0, 0);
        step(0, 0, 64'h0, 1, 0, 0);
        check("full_drain", 64'(delivered - d0), 64'd2);
        step(0, 0, 64'h0, 1, 0, 0);
        check("full_empty", 64'(out_valid), 64'd0);

        // Stall freezes a full stage
        step(0, 1, 64'h20, 0, 0, 0);
        step(0, 1, 64'h21, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 64'h99, 1, 1, 0);
            check("stall_out_valid", 64'(out_valid), 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_data", out_data, 64'h20);
        end
        step(0, 0, 64'h0, 0, 0, 0);
        check("post_stall_valid", 64'(out_valid), 64'd1);
        check("post_stall_data", out_data, 64'h20);
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // Flush a full stage while a new input is offered
        step(0, 1, 64'h30, 0, 0, 1);
        step(0, 0, 64'h0, 0, 0, 0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_bubble", out_data, 64'h0);
`ifdef PIPE_PERF_CNT_EN
        check("flush_cnt", 64'(flush_cnt), 64'd2);
`endif
        step(0, 0, 64'h0, 1, 0, 0);
        step(0, 0, 64'h0, 1, 0, 0);

        // Random handshake and stall traffic
        for (int i = 0; i < 10000; i++) begin
            step(0, 1'($urandom_range(0, 1)), 64'h5A00_0000_0000_0000 + 64'(i),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 0);
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 64'h0, 1, 0, 0);
            if (sb_q.size() == 0) break;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed IF/ID-style pipeline register, used between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque DATA_W payload, e.g. {PC+4, instruction} or control+operand bundles.
- Provides valid/ready handshake, external hazard stall, flush-to-bubble, and a 2-entry skid buffer so in_ready is registered.
- Sustains one transfer per cycle; minimum latency 1 cycle.

Parameters:
- DATA_W, 64, payload width in bits (>=1).
- BUBBLE_DATA, 0, value loaded into payload on reset/flush; all-zero encodes a NOP.
- CNT_W, 16, width of the optional performance counters.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Stall  input  1  hazard stall; freezes all stage state while high.
- Flush  input  1  squash; converts all held entries to bubbles.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload; driven directly from the main register.
- stall_cnt  output  CNT_W  stalled cycles; present only with PIPE_PERF_CNT_EN.
- flush_cnt  output  CNT_W  entries squashed; present only with PIPE_PERF_CNT_EN.

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Occupancy states: EMPTY (!main_v), ONE (main_v & !skid_v), FULL (main_v & skid_v). skid_v & !main_v is illegal; assert it never occurs.
- in_fire = in_valid & in_ready & !Stall.
- out_fire = out_valid & out_ready & !Stall.
- in_ready = !skid_v, registered. out_valid = main_v. Both are gated low while Stall=1.
- Transitions:
  - EMPTY: in_fire -> ONE, main_d<=in_data.
  - ONE: in_fire & out_fire -> ONE, main_d<=in_data. in_fire only -> FULL, skid_d<=in_data. out_fire only -> EMPTY.
  - FULL: in_fire impossible. out_fire -> ONE, main_d<=skid_d.
- Stall=1 (and Flush=0): no register changes; handshake outputs read 0 for that cycle.
- Flush=1: next edge main_v=skid_v=0, main_d=skid_d=BUBBLE_DATA. Overrides Stall and any same-cycle in_fire; that input is dropped. Flush with EMPTY is a no-op apart from the data reload.
- Reset=1: next edge same as Flush; priority Reset > Flush > Stall > handshake.
- Reset values: out_valid=0, in_ready=1, out_data=BUBBLE_DATA, counters=0.
- Data ordering: strict FIFO; an entry never overtakes another and is never duplicated.
- Latency: in_fire at edge N -> out_valid at edge N+1 when the stage was EMPTY or out_fire occurred in the same cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with Stall=1 & main_v=1.
  - flush_cnt adds main_v+skid_v on each Flush.
  - Both saturate at all-ones and clear on Reset.
- Undefined: both ports and all counter logic are absent; functional behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - constants for the default DATA_W of each stage (IF_ID_W=64, etc.);
  - a NOP_INSTR constant used as BUBBLE_DATA;
  - enum for occupancy state (EMPTY/ONE/FULL), used by assertions and bench.
- Sub-module: the saturating counter, sat_counter (WIDTH param, inc, inc_amt, clr), instantiated twice under the macro.

Test Plan:
- Reset with in_valid=1, in_data=0xAA -> out_valid=0, out_data=0, in_ready=1; nothing captured during Reset.
- Stream 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8, one per cycle, first at 1 cycle after acceptance.
- out_ready=0, send 0x10, 0x11 -> FULL, in_ready=0 next cycle; out_ready=1 -> 0x10 then 0x11, no loss or duplication.
- FULL holding 0x20/0x21, Stall=1 for 3 cycles -> outputs frozen, handshakes 0; with macro, stall_cnt=3.
- FULL with Flush=1 and in_valid=1, in_data=0x30 same cycle -> EMPTY, out_data=BUBBLE_DATA, 0x30 dropped; flush_cnt=2.
- Random in_valid/out_ready/Stall for 10k cycles vs scoreboard -> in-order delivery, 0 mismatches, illegal-state assertion never fires.
